// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// FSM encoding, operand byte selects and the default pass count.
package nsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } nsa_state_e;

    localparam logic [1:0] SEL_A_LO = 2'd0;
    localparam logic [1:0] SEL_A_HI = 2'd1;
    localparam logic [1:0] SEL_B_LO = 2'd2;
    localparam logic [1:0] SEL_B_HI = 2'd3;

    localparam int NSA_NIBBLES_DEF = 4;

endpackage

// File: rtl/tt_um_nibble_serial_adder16_ks_add4_core.sv
// Combinational 4-bit Kogge-Stone adder with carry-in.
// Two prefix levels (distance 1, then 2) over generate/propagate pairs.
module ks_add4_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] w_g0;
    logic [3:0] w_p0;
    logic [3:0] w_g1;
    logic [3:0] w_p1;
    logic [3:0] w_g2;
    logic [3:0] w_c;

    assign w_g0 = a & b;
    assign w_p0 = a ^ b;

    // Carry-in folded into bit 0 so prefix G[i] means carry out of bit i
    assign w_g1[0] = w_g0[0] | (w_p0[0] & cin);
    assign w_p1[0] = w_p0[0];
    assign w_g1[1] = w_g0[1] | (w_p0[1] & w_g1[0]);
    assign w_p1[1] = w_p0[1] & w_p0[0];
    assign w_g1[2] = w_g0[2] | (w_p0[2] & w_g0[1]);
    assign w_p1[2] = w_p0[2] & w_p0[1];
    assign w_g1[3] = w_g0[3] | (w_p0[3] & w_g0[2]);
    assign w_p1[3] = w_p0[3] & w_p0[2];

    assign w_g2[0] = w_g1[0];
    assign w_g2[1] = w_g1[1];
    assign w_g2[2] = w_g1[2] | (w_p1[2] & w_g1[0]);
    assign w_g2[3] = w_g1[3] | (w_p1[3] & w_g1[1]);

    assign w_c  = {w_g2[2:0], cin};
    assign sum  = w_p0 ^ w_c;
    assign cout = w_g2[3];

endmodule

// File: rtl/tt_um_nibble_serial_adder16.sv
// Nibble-serial adder: one 4-bit Kogge-Stone pass per clock, LSB first.
// Define NSA_ACCUM_EN to copy each finished sum back into operand A.
module tt_um_nibble_serial_adder16
    import nsa_pkg::*;
#(
    parameter int NIBBLES = NSA_NIBBLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);
    localparam bit         HI_EN    = (NIBBLES == 4);

    nsa_state_e  r_state;
    nsa_state_e  w_next;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_sum;
    logic [15:0] w_sum_next;
    logic [1:0]  r_idx;
    logic        r_carry;
    logic        r_cout;
    logic        r_start_q;
    logic [3:0]  w_nib_a;
    logic [3:0]  w_nib_b;
    logic [3:0]  w_nib_s;
    logic        w_nib_c;
    logic        w_start_req;
    logic        w_load;
    logic        w_last;
    logic        w_busy;
    logic        w_done;
    logic [1:0]  w_sel;
    logic        w_unused;

    assign w_unused    = &{1'b0, ena, uio_in[7:5]};
    assign w_sel       = uio_in[2:1];
    assign w_start_req = uio_in[3] & ~r_start_q;
    assign w_load      = uio_in[0] && (r_state != ST_ADD);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_nib_a     = r_a[{r_idx, 2'b00} +: 4];
    assign w_nib_b     = r_b[{r_idx, 2'b00} +: 4];

    ks_add4_core u_add (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .sum  (w_nib_s),
        .cout (w_nib_c)
    );

    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[{r_idx, 2'b00} +: 4] = w_nib_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_req) w_next = ST_ADD;
            ST_ADD:           if (w_last)      w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ST_ADD);
        w_done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= uio_in[3];
            if (w_start_req && r_state != ST_ADD) begin
                r_sum   <= '0;
                r_idx   <= '0;
                r_carry <= 1'b0;
                r_cout  <= 1'b0;
            end else if (r_state == ST_ADD) begin
                r_sum   <= w_sum_next;
                r_carry <= w_nib_c;
                r_idx   <= r_idx + 2'd1;
                if (w_last) r_cout <= w_nib_c;
            end
            // Load lands in the same edge as a start; ADD reads it next edge
            if (w_load) begin
                case (w_sel)
                    SEL_A_LO: r_a[7:0] <= ui_in;
                    SEL_A_HI: if (HI_EN) r_a[15:8] <= ui_in;
                    SEL_B_LO: r_b[7:0] <= ui_in;
                    SEL_B_HI: if (HI_EN) r_b[15:8] <= ui_in;
                    default: ;
                endcase
            end
`ifdef NSA_ACCUM_EN
            if (r_state == ST_ADD && w_last) r_a <= w_sum_next;
`endif
        end
    end

    assign uo_out  = uio_in[4] ? r_sum[15:8] : r_sum[7:0];
    assign uio_out = {r_cout, w_done, w_busy, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule
